// File: rtl/axis_packet_source_pkg.sv
// Shared types and defaults for the AXI-Stream packet generator.
package axis_packet_source_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_GAP_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } src_state_t;

    // Zero-length packets are sent as a single beat; returns beats-1.
    function automatic logic [DEF_LEN_WIDTH-1:0] len_minus_one(input logic [DEF_LEN_WIDTH-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

endpackage

// File: rtl/axis_src_counter.sv
// Loadable down-counter with zero / one flags for beat, packet and gap counting.
// Latency: load/decrement take effect on the next clk edge; flags decode the current count.
// Backpressure: none; the owner decides when to decrement.
module axis_src_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    localparam logic [W-1:0] ONE = W'(1);

    // Load wins over decrement; the count saturates at zero so a stray
    // decrement can never wrap a long packet back to the top.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == ONE);

endmodule

// File: rtl/axis_packet_source.sv
// AXI-Stream master emitting pkt_count packets of pkt_len incrementing beats with optional gaps.
// Latency: first beat valid one cycle after an accepted start; done two cycles after the last transfer.
// Backpressure: tvalid/tdata/tlast are registered and held until tready accepts the beat.
module axis_packet_source
    import axis_packet_source_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int GAP_WIDTH  = DEF_GAP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [CNT_WIDTH-1:0]  pkt_count,
    input  logic [DATA_WIDTH-1:0] first_data,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  pkts_sent
);

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = GAP_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

    src_state_t state_q, state_d;

    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q,  tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q,  tdata_d;
    logic [CNT_WIDTH-1:0]  pkts_q,   pkts_d;
    logic [LEN_WIDTH-1:0]  len_m1_q, len_m1_d;
    logic [GAP_WIDTH-1:0]  gap_q,    gap_d;

    logic                  beat_load, beat_dec, beat_zero, beat_one;
    logic [LEN_WIDTH-1:0]  beat_load_val;
    logic                  pkt_load, pkt_dec, pkt_zero, pkt_one;
    logic [CNT_WIDTH-1:0]  pkt_load_val;
    logic                  gap_load, gap_dec, gap_zero, gap_one;
    logic [GAP_WIDTH-1:0]  gap_load_val;

    logic                  xfer;
    logic [LEN_WIDTH-1:0]  start_len_m1;
    logic                  unused_flags;

    assign xfer         = tvalid_q && m_axis_tready;
    assign start_len_m1 = (pkt_len == '0) ? '0 : pkt_len - LEN_ONE;
    assign unused_flags = beat_zero ^ pkt_one ^ gap_one;

    // Beats remaining after the one currently presented.
    axis_src_counter #(.W(LEN_WIDTH)) u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (beat_load),
        .load_val (beat_load_val),
        .dec      (beat_dec),
        .zero     (beat_zero),
        .one      (beat_one)
    );

    // Packets remaining after the one in flight.
    axis_src_counter #(.W(CNT_WIDTH)) u_pkt_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (pkt_load),
        .load_val (pkt_load_val),
        .dec      (pkt_dec),
        .zero     (pkt_zero),
        .one      (pkt_one)
    );

    // Idle cycles remaining after the current one.
    axis_src_counter #(.W(GAP_WIDTH)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_load_val),
        .dec      (gap_dec),
        .zero     (gap_zero),
        .one      (gap_one)
    );

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tdata_d       = tdata_q;
        pkts_d        = pkts_q;
        len_m1_d      = len_m1_q;
        gap_d         = gap_q;
        beat_load     = 1'b0;
        beat_load_val = len_m1_q;
        beat_dec      = 1'b0;
        pkt_load      = 1'b0;
        pkt_load_val  = pkt_count - CNT_ONE;
        pkt_dec       = 1'b0;
        gap_load      = 1'b0;
        gap_load_val  = gap_q - GAP_ONE;
        gap_dec       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d   = 1'b1;
                    pkts_d   = '0;
                    len_m1_d = start_len_m1;
                    gap_d    = gap_cycles;
                    tdata_d  = first_data;
                    if (pkt_count == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d       = ST_SEND;
                        tvalid_d      = 1'b1;
                        tlast_d       = (start_len_m1 == '0);
                        beat_load     = 1'b1;
                        beat_load_val = start_len_m1;
                        pkt_load      = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (xfer) begin
                    tdata_d = tdata_q + DATA_ONE;
                    if (tlast_q) begin
                        pkts_d = pkts_q + CNT_ONE;
                        if (pkt_zero) begin
                            state_d  = ST_FIN;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end else if (gap_q == '0) begin
                            pkt_dec   = 1'b1;
                            beat_load = 1'b1;
                            tlast_d   = (len_m1_q == '0);
                        end else begin
                            state_d  = ST_GAP;
                            pkt_dec  = 1'b1;
                            gap_load = 1'b1;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        beat_dec = 1'b1;
                        tlast_d  = beat_one;
                    end
                end
            end

            ST_GAP: begin
                if (gap_zero) begin
                    state_d   = ST_SEND;
                    tvalid_d  = 1'b1;
                    tlast_d   = (len_m1_q == '0);
                    beat_load = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end

            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            pkts_q   <= '0;
            len_m1_q <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            pkts_q   <= pkts_d;
            len_m1_q <= len_m1_d;
            gap_q    <= gap_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign pkts_sent     = pkts_q;

endmodule
